// File: rtl/ring_input_port.sv
// ring_input_port: receiving end of one ring link. Buffers packets arriving
// from the neighbouring router in a first-word-fall-through FIFO, presents the
// head packet to the local switch through valid/ready, and returns on/off
// backpressure to the neighbour based on the post-update occupancy.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   link_in           packet from neighbour; MSB set means a packet is present
//   backpressure_wr   16'h0000 = ON (send), 16'h0001 = OFF (stop)
//   out_packet        head-of-FIFO packet (combinational from storage)
//   out_valid         FIFO non-empty
//   out_ready         consumer accepts the head this cycle
//   out_is_local      head destination equals ROUTER_ID
//   occupancy         current FIFO count
//   overflow          sticky: a packet was dropped because the FIFO was full
//   pkt_in_count      packets accepted (wrapping 32-bit)
//   pkt_drop_count    packets dropped (wrapping 32-bit)
module ring_input_port #(
    parameter int unsigned PACKET_SIZE   = 49,
    parameter int unsigned BUFFER_SIZE   = 4,
    parameter int unsigned OFF_THRESHOLD = 2,
    parameter int unsigned ON_THRESHOLD  = 1,
    parameter int unsigned ROUTER_ID     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PACKET_SIZE-1:0]         link_in,
    output logic [15:0]                    backpressure_wr,
    output logic [PACKET_SIZE-1:0]         out_packet,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_is_local,
    output logic [$clog2(BUFFER_SIZE):0]   occupancy,
    output logic                           overflow,
    output logic [31:0]                    pkt_in_count,
    output logic [31:0]                    pkt_drop_count
);

    localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        BP_ON  = 1'b0,
        BP_OFF = 1'b1
    } bp_state_e;

    logic [PACKET_SIZE-1:0] mem_q [BUFFER_SIZE];
    logic [PACKET_SIZE-1:0] mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [31:0]            pkt_in_count_q, pkt_in_count_d;
    logic [31:0]            pkt_drop_count_q, pkt_drop_count_d;
    bp_state_e              bp_state_q, bp_state_d;

    logic push_req;
    logic pop;
    logic full;
    logic push_acc;
    logic drop;

    // Handshake decode: a full FIFO still accepts a push when the head leaves
    // in the same cycle.
    always_comb begin
        push_req = link_in[PACKET_SIZE-1];
        pop      = out_valid & out_ready;
        full     = (count_q == CNT_W'(BUFFER_SIZE));
        push_acc = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Next-state for pointers, occupancy, sticky flag and statistics.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        overflow_d       = overflow_q;
        pkt_in_count_d   = pkt_in_count_q;
        pkt_drop_count_d = pkt_drop_count_q;

        if (push_acc) begin
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
            pkt_in_count_d = pkt_in_count_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_acc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d       = 1'b1;
            pkt_drop_count_d = pkt_drop_count_q + 32'd1;
        end
    end

    // Storage write.
    always_comb begin
        mem_d = mem_q;
        if (push_acc) begin
            mem_d[wr_ptr_q] = link_in;
        end
    end

    // Storage is not reset: out_valid derives only from count, so stale
    // contents never reach the handshake.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            overflow_q       <= 1'b0;
            pkt_in_count_q   <= '0;
            pkt_drop_count_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            overflow_q       <= overflow_d;
            pkt_in_count_q   <= pkt_in_count_d;
            pkt_drop_count_q <= pkt_drop_count_d;
        end
    end

    // Backpressure FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_state_q <= BP_ON;
        end else begin
            bp_state_q <= bp_state_d;
        end
    end

    // Backpressure FSM: next state from post-update occupancy, so the
    // indication flips on the same edge the threshold is reached.
    always_comb begin
        bp_state_d = bp_state_q;
        case (bp_state_q)
            BP_ON: begin
                if (count_d >= CNT_W'(OFF_THRESHOLD)) begin
                    bp_state_d = BP_OFF;
                end
            end
            BP_OFF: begin
                if (count_d <= CNT_W'(ON_THRESHOLD)) begin
                    bp_state_d = BP_ON;
                end
            end
            default: bp_state_d = BP_ON;
        endcase
    end

    // Backpressure FSM: output decode of the registered state.
    always_comb begin
        backpressure_wr = 16'h0000;
        if (bp_state_q == BP_OFF) begin
            backpressure_wr = 16'h0001;
        end
    end

    // Head presentation and status outputs.
    always_comb begin
        out_packet     = mem_q[rd_ptr_q];
        out_valid      = (count_q != '0);
        out_is_local   = (out_packet[15:0] == 16'(ROUTER_ID));
        occupancy      = count_q;
        overflow       = overflow_q;
        pkt_in_count   = pkt_in_count_q;
        pkt_drop_count = pkt_drop_count_q;
    end

endmodule
